// File: rtl/npc_pkg.sv
// Shared execute-stage definitions: ALU selects plus divider op bits, states and trip counts.
package npc_pkg;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluSll,
    AluSlt,
    AluSltu,
    AluXor,
    AluSrl,
    AluSra,
    AluOr,
    AluAnd
  } alu_sel_e;

  // Divider op field is {is_word, is_rem, is_signed}
  localparam int unsigned DivOpWord   = 2;
  localparam int unsigned DivOpRem    = 1;
  localparam int unsigned DivOpSigned = 0;

  localparam int unsigned DivIterDword = 64;
  localparam int unsigned DivIterWord  = 32;
  localparam int unsigned DivCntW      = 7;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivCalc = 2'd1,
    DivDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the RV64M div/rem family, one quotient bit per cycle.
module div_unit
  import npc_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  input  logic         flush
);

  function automatic logic [N-1:0] neg_if(input logic [N-1:0] x, input logic c);
    return c ? -x : x;
  endfunction

  function automatic logic [N-1:0] sext32(input logic [N-1:0] x);
    return {{(N-32){x[31]}}, x[31:0]};
  endfunction

  div_state_e         state_q, state_d;
  logic [DivCntW-1:0] cnt_q;
  logic [N-1:0]       rem_q, quo_q, dvs_q, res_q;
  logic               q_neg_q, r_neg_q, is_rem_q, is_word_q;

  logic         is_word, is_rem, is_signed;
  logic [N-1:0] a_ext, b_ext, a_mag, b_mag, dz_res;
  logic         sa, sb, b_zero;

  logic [N:0]   shifted;
  logic         ge;
  logic [N-1:0] rem_nx, quo_nx, q_fix, r_fix, sel_fix, fin_res;

  assign is_word   = op[DivOpWord];
  assign is_rem    = op[DivOpRem];
  assign is_signed = op[DivOpSigned];

  // Request decode: extend word operands, take magnitudes, detect zero divisor.
  always_comb begin
    a_ext = A;
    b_ext = B;
    if (is_word) begin
      a_ext = is_signed ? sext32(A) : {{(N-32){1'b0}}, A[31:0]};
      b_ext = is_signed ? sext32(B) : {{(N-32){1'b0}}, B[31:0]};
    end
    sa     = is_signed & a_ext[N-1];
    sb     = is_signed & b_ext[N-1];
    a_mag  = neg_if(a_ext, sa);
    b_mag  = neg_if(b_ext, sb);
    b_zero = (b_ext == '0);
    dz_res = is_rem ? (is_word ? sext32(a_ext) : a_ext) : '1;
  end

  // One restoring step plus the sign/select fixup applied on the final step.
  always_comb begin
    shifted = {rem_q, quo_q[N-1]};
    ge      = (shifted >= {1'b0, dvs_q});
    rem_nx  = ge ? (shifted[N-1:0] - dvs_q) : shifted[N-1:0];
    quo_nx  = {quo_q[N-2:0], ge};
    q_fix   = neg_if(quo_nx, q_neg_q);
    r_fix   = neg_if(rem_nx, r_neg_q);
    sel_fix = is_rem_q ? r_fix : q_fix;
    fin_res = is_word_q ? sext32(sel_fix) : sel_fix;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DivIdle: if (in_valid) state_d = b_zero ? DivDone : DivCalc;
      DivCalc: if (cnt_q == DivCntW'(1)) state_d = DivDone;
      DivDone: if (out_ready) state_d = DivIdle;
      default: state_d = DivIdle;
    endcase
    if (flush) state_d = DivIdle;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= DivIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      is_rem_q  <= 1'b0;
      is_word_q <= 1'b0;
    end else if (!flush) begin
      unique case (state_q)
        DivIdle: begin
          if (in_valid) begin
            is_rem_q  <= is_rem;
            is_word_q <= is_word;
            q_neg_q   <= sa ^ sb;
            r_neg_q   <= sa;
            rem_q     <= '0;
            dvs_q     <= b_mag;
            // Word dividends sit in the top half so 32 shifts consume exactly their bits
            quo_q     <= is_word ? {a_mag[31:0], {(N-32){1'b0}}} : a_mag;
            cnt_q     <= is_word ? DivCntW'(DivIterWord) : DivCntW'(DivIterDword);
            if (b_zero) res_q <= dz_res;
          end
        end
        DivCalc: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - DivCntW'(1);
          if (cnt_q == DivCntW'(1)) res_q <= fin_res;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == DivIdle);
  assign out_valid = (state_q == DivDone);
  assign res       = res_q;

endmodule
